// File: rtl/decode_reg_file_sb.sv
// RV32 register-operand decode stage with a per-register pending-write scoreboard.
// Stalls on RAW against in-flight writes and on WAW counter saturation.

module decode_reg_file_sb_cnt #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_err
);
  logic [CNT_W-1:0] r_cnt;

  // A simultaneous inc and dec cancel, so the underflow case needs dec alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_cnt <= '0;
    else if (i_inc && !i_dec)                  r_cnt <= r_cnt + 1'b1;
    else if (i_dec && !i_inc && r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
  end

  assign o_cnt = r_cnt;
  assign o_err = i_dec && !i_inc && (r_cnt == '0);
endmodule

module decode_reg_file_sb #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned CNT_W    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic        out_rd_we,
  output logic        out_illegal,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  output logic        sb_err
);
  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam logic [CNT_W:0] MAX_PEND = (CNT_W+1)'((1 << CNT_W) - 1);

  function automatic logic in_rng(input logic [4:0] idx);
    return 32'(idx) < NUM_REGS;
  endfunction

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic [4:0] w_rs1, w_rs2, w_rd;
  logic w_lui, w_auipc, w_jal, w_opr, w_store, w_branch, w_system, w_csri;
  logic w_rs1_used, w_rs2_used, w_rd_we, w_illegal;
  logic w_unused;

  assign w_op     = in_instr[6:0];
  assign w_f3     = in_instr[14:12];
  assign w_lui    = (w_op == 7'b0110111);
  assign w_auipc  = (w_op == 7'b0010111);
  assign w_jal    = (w_op == 7'b1101111);
  assign w_opr    = (w_op == 7'b0110011);
  assign w_store  = (w_op == 7'b0100011);
  assign w_branch = (w_op == 7'b1100011);
  assign w_system = (w_op == 7'b1110011);
  assign w_csri   = w_system && w_f3[2] && (w_f3 != 3'd0);

  // CSRxxI reuse the rs1 field as an immediate; LUI has no source at all.
  assign w_rs1      = (w_lui || w_csri) ? 5'd0 : in_instr[19:15];
  assign w_rs2      = in_instr[24:20];
  assign w_rd       = in_instr[11:7];
  assign w_rs1_used = !(w_lui || w_auipc || w_jal || w_csri);
  assign w_rs2_used = w_opr || w_store || w_branch;
  assign w_rd_we    = !(w_store || w_branch || (w_system && w_f3 == 3'd0)) && (w_rd != 5'd0);
  assign w_illegal  = (w_rs1_used && !in_rng(w_rs1)) || (w_rs2_used && !in_rng(w_rs2)) ||
                      (w_rd_we && !in_rng(w_rd));
  assign w_unused   = ^in_instr[31:25];

  logic             r_out_valid, r_out_rd_we, r_out_illegal, r_sb_err;
  logic [4:0]       r_out_rs1, r_out_rs2, r_out_rd;
  logic [NUM_REGS-1:0][CNT_W-1:0] w_cnt;
  logic [NUM_REGS-1:0]            w_err;
  logic [CNT_W-1:0] w_cnt_rs1, w_cnt_rs2, w_cnt_rd;
  logic w_hit_rs1, w_hit_rs2, w_hit_rd, w_busy_rs1, w_busy_rs2, w_rd_full, w_hazard;
  logic w_accept, w_inc, w_dec;

  assign w_cnt_rs1 = in_rng(w_rs1) ? w_cnt[w_rs1[IDX_W-1:0]] : '0;
  assign w_cnt_rs2 = in_rng(w_rs2) ? w_cnt[w_rs2[IDX_W-1:0]] : '0;
  assign w_cnt_rd  = in_rng(w_rd)  ? w_cnt[w_rd[IDX_W-1:0]]  : '0;

  // The held output is not yet counted, so it is treated as one more pending write.
  assign w_hit_rs1  = r_out_valid && r_out_rd_we && (r_out_rd == w_rs1);
  assign w_hit_rs2  = r_out_valid && r_out_rd_we && (r_out_rd == w_rs2);
  assign w_hit_rd   = r_out_valid && r_out_rd_we && (r_out_rd == w_rd);
  assign w_busy_rs1 = (w_rs1 != 5'd0) && ((w_cnt_rs1 != '0) || w_hit_rs1);
  assign w_busy_rs2 = (w_rs2 != 5'd0) && ((w_cnt_rs2 != '0) || w_hit_rs2);
  assign w_rd_full  = ({1'b0, w_cnt_rd} + {{CNT_W{1'b0}}, w_hit_rd}) >= MAX_PEND;
  assign w_hazard   = (w_rs1_used && w_busy_rs1) || (w_rs2_used && w_busy_rs2) ||
                      (w_rd_we && w_rd_full);

  assign in_ready = (!r_out_valid || out_ready) && !w_hazard && !flush;
  assign w_accept = in_valid && in_ready;
  assign w_inc    = r_out_valid && out_ready && r_out_rd_we && !flush;
  assign w_dec    = wb_valid && (wb_rd != 5'd0) && in_rng(wb_rd);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
    decode_reg_file_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_inc && (r_out_rd == 5'(g))),
      .i_dec (w_dec && (wb_rd == 5'(g))),
      .o_cnt (w_cnt[g]),
      .o_err (w_err[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_rs1     <= '0;
      r_out_rs2     <= '0;
      r_out_rd      <= '0;
      r_out_rd_we   <= 1'b0;
      r_out_illegal <= 1'b0;
      r_sb_err      <= 1'b0;
    end else begin
      r_sb_err <= r_sb_err || (|w_err);
      if (w_accept) begin
        r_out_valid   <= 1'b1;
        r_out_rs1     <= w_rs1;
        r_out_rs2     <= w_rs2;
        r_out_rd      <= w_rd;
        r_out_rd_we   <= w_rd_we && !w_illegal;
        r_out_illegal <= w_illegal;
      end else if (flush || out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_rs1     = r_out_rs1;
  assign out_rs2     = r_out_rs2;
  assign out_rd      = r_out_rd;
  assign out_rd_we   = r_out_rd_we;
  assign out_illegal = r_out_illegal;
  assign sb_err      = r_sb_err;
endmodule

// File: tb/tb_decode_reg_file_sb.sv
// Directed bench: RV32I instance with an expected-output queue, plus an RV32E instance.
module tb_decode_reg_file_sb;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic in_valid = 0, out_ready = 1, wb_valid = 0, flush = 0;
  logic [31:0] in_instr = '0;
  logic [4:0]  wb_rd = '0;
  logic in_ready, out_valid, out_rd_we, out_illegal, sb_err;
  logic [4:0] out_rs1, out_rs2, out_rd;

  logic e_in_valid = 0, e_wb_valid = 0;
  logic [31:0] e_in_instr = '0;
  logic [4:0]  e_wb_rd = '0;
  logic e_in_ready, e_out_valid, e_out_rd_we, e_out_illegal, e_sb_err;
  logic [4:0] e_out_rs1, e_out_rs2, e_out_rd;

  decode_reg_file_sb #(.NUM_REGS(32), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_illegal(out_illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .sb_err(sb_err));

  decode_reg_file_sb #(.NUM_REGS(16), .CNT_W(2)) dut_e (
    .clk(clk), .rst_n(rst_n), .in_valid(e_in_valid), .in_ready(e_in_ready), .in_instr(e_in_instr),
    .out_valid(e_out_valid), .out_ready(1'b1), .out_rs1(e_out_rs1), .out_rs2(e_out_rs2),
    .out_rd(e_out_rd), .out_rd_we(e_out_rd_we), .out_illegal(e_out_illegal),
    .wb_valid(e_wb_valid), .wb_rd(e_wb_rd), .flush(1'b0), .sb_err(e_sb_err));

  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic       we, ill;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0;

  function automatic logic [31:0] r_add(input logic [4:0] rd, rs1, rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_addi(input logic [4:0] rd, rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic exp_t model(input logic [31:0] i, input int unsigned nr);
    exp_t e;
    logic [6:0] opc = i[6:0];
    logic [2:0] f3 = i[14:12];
    logic csri = (opc == 7'h73) && f3[2];
    logic u1 = !(opc == 7'h37 || opc == 7'h17 || opc == 7'h6F || csri);
    logic u2 = (opc == 7'h33 || opc == 7'h23 || opc == 7'h63);
    logic wr = !(opc == 7'h23 || opc == 7'h63 || (opc == 7'h73 && f3 == 3'd0)) && i[11:7] != 0;
    e.rs1 = (opc == 7'h37 || csri) ? 5'd0 : i[19:15];
    e.rs2 = i[24:20];
    e.rd  = i[11:7];
    e.ill = (u1 && int'(e.rs1) >= nr) || (u2 && int'(e.rs2) >= nr) || (wr && int'(e.rd) >= nr);
    e.we  = wr && !e.ill;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rdy(input string tag, input logic exp);
    #1 chk(tag, 32'(in_ready), 32'(exp));
  endtask

  // One clock: retire/compare the head on hand-off or flush, queue the accepted word.
  task automatic cyc();
    exp_t e;
    #1;
    if (out_valid && (out_ready || flush)) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $error("FAIL sb_unexpected observed=rd%0d expected=none", out_rd);
      end else begin
        e = q.pop_front();
        chk("sb_out", 32'({out_rs1, out_rs2, out_rd, out_rd_we, out_illegal}), 32'(e));
      end
    end
    if (in_valid && in_ready) q.push_back(model(in_instr, 32));
    @(negedge clk);
  endtask

  initial begin
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_fields", 32'({out_rs1, out_rs2, out_rd, out_rd_we, out_illegal}), 0);
    chk("rst_sb_err", 32'(sb_err), 0);
    @(negedge clk) rst_n = 1'b1;

    // x0 override for LUI and CSRRWI
    in_valid = 1; in_instr = 32'h000011B7;
    rdy("lui_ready", 1); cyc();
    chk("lui_vld", 32'(out_valid), 1);
    chk("lui_rs1", 32'(out_rs1), 0);
    chk("lui_rd", 32'({out_rd, out_rd_we}), 32'({5'd3, 1'b1}));
    in_instr = 32'h3003D273;
    rdy("csri_ready", 1); cyc();
    chk("csri_rs1", 32'(out_rs1), 0);
    chk("csri_rd", 32'({out_rd, out_rd_we}), 32'({5'd4, 1'b1}));
    in_valid = 0; cyc();

    // RAW stall on x5 until writeback retires
    in_valid = 1; in_instr = i_addi(5, 0, 1); cyc();
    in_instr = r_add(6, 5, 5);
    repeat (3) begin rdy("raw_stall", 0); cyc(); end
    wb_valid = 1; wb_rd = 5;
    rdy("raw_no_bypass", 0); cyc();
    wb_valid = 0;
    rdy("raw_release", 1); cyc();
    in_valid = 0; cyc();

    // WAW saturation on x7
    in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      in_instr = i_addi(7, 0, 12'(k)); rdy("waw_issue", 1); cyc();
    end
    in_instr = i_addi(7, 0, 3);
    repeat (3) begin rdy("waw_stall", 0); cyc(); end
    wb_valid = 1; wb_rd = 7;
    rdy("waw_wb_cycle", 0); cyc();
    wb_valid = 0;
    rdy("waw_release", 1); cyc();
    in_valid = 0; cyc();

    // Backpressure holds outputs; flush drops without counting
    out_ready = 0; in_valid = 1; in_instr = r_add(9, 10, 11); cyc();
    in_instr = r_add(12, 1, 2);
    rdy("bp_ready", 0);
    in_valid = 0;
    repeat (5) begin
      chk("bp_hold", 32'({out_valid, out_rs1, out_rs2, out_rd, out_rd_we}),
          32'({1'b1, 5'd10, 5'd11, 5'd9, 1'b1}));
      cyc();
    end
    flush = 1; in_valid = 1;
    rdy("flush_ready", 0); cyc();
    flush = 0; out_ready = 1;
    chk("flush_vld", 32'(out_valid), 0);
    in_instr = r_add(13, 9, 9);
    rdy("flush_no_count", 1); cyc();
    in_valid = 0; cyc();

    // Asynchronous reset mid-stream with cnt[5]=2 and a held output
    in_valid = 1;
    repeat (3) begin in_instr = i_addi(5, 0, 2); cyc(); end
    in_valid = 0; out_ready = 0;
    in_instr = r_add(14, 5, 0);
    rdy("pre_rst_stall", 0);
    #2 rst_n = 0;
    #1;
    chk("arst_vld", 32'(out_valid), 0);
    chk("arst_sb_err", 32'(sb_err), 0);
    q.delete();
    @(negedge clk) rst_n = 1;
    out_ready = 1; in_valid = 1; in_instr = r_add(13, 5, 5);
    rdy("post_rst_ready", 1); cyc();
    in_valid = 0; cyc();
    chk("sb_drained", 32'(q.size()), 0);
    chk("sb_err_clean", 32'(sb_err), 0);

    // RV32E instance: illegal index, out-of-range wb ignored, underflow is sticky
    e_in_valid = 1; e_in_instr = r_add(20, 1, 2);
    #1 chk("e_ready", 32'(e_in_ready), 1);
    @(negedge clk);
    chk("e_illegal", 32'({e_out_valid, e_out_illegal, e_out_rd_we}), 32'(3'b110));
    e_in_instr = r_add(3, 1, 2);
    @(negedge clk);
    chk("e_legal", 32'({e_out_illegal, e_out_rd_we, e_out_rd}), 32'({1'b0, 1'b1, 5'd3}));
    e_in_valid = 0;
    e_wb_valid = 1; e_wb_rd = 20;
    @(negedge clk);
    chk("e_wb_oob", 32'(e_sb_err), 0);
    e_wb_rd = 9;
    @(negedge clk);
    e_wb_valid = 0;
    chk("e_sb_err_set", 32'(e_sb_err), 1);
    repeat (3) @(negedge clk);
    chk("e_sb_err_sticky", 32'(e_sb_err), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
